// File: rtl/modadd_sched_pkg.sv
// Shared constants, index type and round-robin pointer helper for the
// modadd scheduler slice.
package modadd_sched_pkg;

    localparam int MAX_NUM_REQ    = 8;
    localparam int MAX_MODADD_LAT = 2;
    localparam int IDX_W          = $clog2(MAX_NUM_REQ);

    typedef logic [IDX_W-1:0] req_idx_t;

    // Pointer moves just past the granted requester; an out-of-range index keeps it.
    function automatic req_idx_t rr_next(input req_idx_t ptr, input req_idx_t grant_idx,
                                         input int n);
        if (int'(grant_idx) >= n) begin
            return ptr;
        end
        return req_idx_t'((int'(grant_idx) + 1) % n);
    endfunction

endpackage

// File: rtl/modadd.sv
// Modular adder c = (a + b) mod q with q = qH*2^WORD_SIZE + 1 (or constant Q_VALUE),
// MODADD_LAT register stages on the datapath.
module modadd #(
    parameter int LOGQ       = 16,
    parameter int WORD_SIZE  = 8,
    parameter int Q_VALUE    = 0,
    parameter int MODADD_LAT = 2
) (
    input  logic                      clk,
    input  logic [LOGQ-1:0]           a,
    input  logic [LOGQ-1:0]           b,
    input  logic [LOGQ-WORD_SIZE-1:0] qH,
    output logic [LOGQ-1:0]           c
);

    logic [LOGQ-1:0] q;
    logic [LOGQ:0]   sum;

    assign q   = (Q_VALUE != 0) ? LOGQ'(Q_VALUE) : {qH, {(WORD_SIZE-1){1'b0}}, 1'b1};
    assign sum = {1'b0, a} + {1'b0, b};

    // sum < 2q, so one conditional subtraction is enough; the borrow picks the branch.
    function automatic logic [LOGQ-1:0] reduce(input logic [LOGQ:0] s, input logic [LOGQ-1:0] m);
        logic [LOGQ:0] d;
        d = s - {1'b0, m};
        return d[LOGQ] ? s[LOGQ-1:0] : d[LOGQ-1:0];
    endfunction

    if (MODADD_LAT == 0) begin : g_lat0
        logic unused_clk;
        assign unused_clk = clk;
        assign c = reduce(sum, q);
    end else if (MODADD_LAT == 1) begin : g_lat1
        logic [LOGQ-1:0] c_q;
        // NOTE: datapath registers carry no reset; the scheduler's cleared tags mask them.
        always_ff @(posedge clk) begin
            c_q <= reduce(sum, q);
        end
        assign c = c_q;
    end else begin : g_lat2
        logic [LOGQ:0]   sum_q;
        logic [LOGQ-1:0] c_q;
        always_ff @(posedge clk) begin
            sum_q <= sum;
            c_q   <= reduce(sum_q, q);
        end
        assign c = c_q;
    end

endmodule

// File: rtl/modadd_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter
    import modadd_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] grant,
    output req_idx_t           grant_idx,
    output logic               any_grant
);

    logic [MAX_NUM_REQ-1:0] req_ext;
    req_idx_t               cand;

    assign req_ext = MAX_NUM_REQ'(req);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = req_idx_t'((int'(ptr) + k) % NUM_REQ);
            if (!any_grant && req_ext[cand]) begin
                any_grant = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/modadd_sched.sv
// Shares one modadd among NUM_REQ requesters: round-robin grant, operand mux,
// requester-id tags tracking the adder pipeline, one-hot response bus.
module modadd_sched
    import modadd_sched_pkg::*;
#(
    parameter int LOGQ       = 16,
    parameter int WORD_SIZE  = 8,
    parameter int Q_VALUE    = 0,
    parameter int NUM_REQ    = 4,
    parameter int MODADD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LOGQ-WORD_SIZE-1:0] qH,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*LOGQ-1:0]   req_a,
    input  logic [NUM_REQ*LOGQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [LOGQ-1:0]           rsp_c,
    output logic                      busy,
    output logic [31:0]               op_cnt
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("modadd_sched: NUM_REQ must be in 2..%0d", MAX_NUM_REQ);
    end
    if (MODADD_LAT < 0 || MODADD_LAT > MAX_MODADD_LAT) begin : g_bad_lat
        $error("modadd_sched: MODADD_LAT must be in 0..%0d", MAX_MODADD_LAT);
    end

    typedef struct packed {
        logic               valid;
        logic [NUM_REQ-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0] grant;
    req_idx_t           grant_idx;
    req_idx_t           ptr;
    logic               any_grant;
    logic               issue;
    logic [LOGQ-1:0]    op_a;
    logic [LOGQ-1:0]    op_b;
    logic [LOGQ-1:0]    add_c;
    logic [NUM_REQ-1:0] rsp_id;
    logic [31:0]        cnt_q;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any_grant(any_grant)
    );

    // Gating with rst_n keeps req_ready (and thus any transfer) low throughout reset.
    assign issue     = any_grant & rst_n;
    assign req_ready = issue ? grant : '0;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            cnt_q <= '0;
        end else if (issue) begin
            ptr   <= rr_next(ptr, grant_idx, NUM_REQ);
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign op_cnt = cnt_q;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                op_a = req_a[i*LOGQ +: LOGQ];
                op_b = req_b[i*LOGQ +: LOGQ];
            end
        end
    end

    modadd #(
        .LOGQ      (LOGQ),
        .WORD_SIZE (WORD_SIZE),
        .Q_VALUE   (Q_VALUE),
        .MODADD_LAT(MODADD_LAT)
    ) u_add (
        .clk(clk),
        .a  (op_a),
        .b  (op_b),
        .qH (qH),
        .c  (add_c)
    );

    if (MODADD_LAT == 0) begin : g_tag_comb
        assign rsp_id = req_ready;
        assign busy   = 1'b0;
    end else begin : g_tag_pipe
        tag_t tag_q [MODADD_LAT];

        // One stage per adder register, so the tag leaves with its own sum.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < MODADD_LAT; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                tag_q[0] <= '{valid: issue, id: req_ready};
                for (int i = 1; i < MODADD_LAT; i++) begin
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end

        always_comb begin
            busy = 1'b0;
            for (int i = 0; i < MODADD_LAT; i++) begin
                busy = busy | tag_q[i].valid;
            end
        end

        assign rsp_id = tag_q[MODADD_LAT-1].valid ? tag_q[MODADD_LAT-1].id : '0;
    end

    assign rsp_valid = rsp_id;
    assign rsp_c     = (|rsp_id) ? add_c : '0;

endmodule

// File: tb/tb_modadd_sched.sv
// Drives identical stimulus into three scheduler builds (latency 0, 1, 2) and checks
// them against a cycle-indexed reference model plus table vectors and corner sequences.
module tb_modadd_sched;

    localparam int        LOGQ      = 16;
    localparam int        WORD_SIZE = 8;
    localparam int        NUM_REQ   = 4;
    localparam logic [7:0] QH       = 8'h0F;
    localparam int        Q         = 3841;
    localparam int        HIST      = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*LOGQ-1:0] req_a;
    logic [NUM_REQ*LOGQ-1:0] req_b;
    logic [NUM_REQ-1:0]      ready_w [3];
    logic [NUM_REQ-1:0]      rsp_v_w [3];
    logic [LOGQ-1:0]         rsp_c_w [3];
    logic                    busy_w  [3];
    logic [31:0]             cnt_w   [3];

    modadd_sched #(.LOGQ(LOGQ), .WORD_SIZE(WORD_SIZE), .Q_VALUE(0), .NUM_REQ(NUM_REQ), .MODADD_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .qH(QH), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(ready_w[0]), .rsp_valid(rsp_v_w[0]), .rsp_c(rsp_c_w[0]), .busy(busy_w[0]), .op_cnt(cnt_w[0]));
    modadd_sched #(.LOGQ(LOGQ), .WORD_SIZE(WORD_SIZE), .Q_VALUE(0), .NUM_REQ(NUM_REQ), .MODADD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .qH(QH), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(ready_w[1]), .rsp_valid(rsp_v_w[1]), .rsp_c(rsp_c_w[1]), .busy(busy_w[1]), .op_cnt(cnt_w[1]));
    modadd_sched #(.LOGQ(LOGQ), .WORD_SIZE(WORD_SIZE), .Q_VALUE(0), .NUM_REQ(NUM_REQ), .MODADD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .qH(QH), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(ready_w[2]), .rsp_valid(rsp_v_w[2]), .rsp_c(rsp_c_w[2]), .busy(busy_w[2]), .op_cnt(cnt_w[2]));

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side stimulus state.
    bit vld [NUM_REQ];
    int oa  [NUM_REQ];
    int ob  [NUM_REQ];

    // Reference model: pointer, counter and a per-cycle history of accepted ops.
    int          m_ptr;
    logic [31:0] m_cnt;
    int          m_cyc;
    int          hist_id [HIST];
    int          hist_c  [HIST];
    int          cur_grant;
    int          cur_c;
    int          last_grant;

    typedef struct {
        int req;
        int a;
        int b;
        int c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, m_cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]            = vld[i];
            req_a[i*LOGQ +: LOGQ]   = LOGQ'(oa[i]);
            req_b[i*LOGQ +: LOGQ]   = LOGQ'(ob[i]);
        end
    endtask

    task automatic check_cycle();
        int          gid;
        int          gc;
        int          idx;
        logic        exp_busy;
        logic [31:0] exp_ready;
        cur_grant = -1;
        cur_c     = 0;
        if (!rst_n) begin
            m_ptr = 0;
            m_cnt = '0;
            for (int j = 1; j <= 2; j++) begin
                if (m_cyc - j >= 0) hist_id[m_cyc-j] = -1;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (cur_grant < 0 && vld[(m_ptr + k) % NUM_REQ]) cur_grant = (m_ptr + k) % NUM_REQ;
            end
            if (cur_grant >= 0) cur_c = (oa[cur_grant] + ob[cur_grant]) % Q;
        end
        exp_ready = (cur_grant >= 0) ? (32'd1 << cur_grant) : 32'd0;
        for (int lat = 0; lat < 3; lat++) begin
            gid = -1;
            gc  = 0;
            if (lat == 0) begin
                gid = cur_grant;
                gc  = cur_c;
            end else begin
                idx = m_cyc - lat;
                if (rst_n && idx >= 0 && hist_id[idx] >= 0) begin
                    gid = hist_id[idx];
                    gc  = hist_c[idx];
                end
            end
            exp_busy = 1'b0;
            for (int j = 1; j <= lat; j++) begin
                if (rst_n && m_cyc - j >= 0 && hist_id[m_cyc-j] >= 0) exp_busy = 1'b1;
            end
            check($sformatf("req_ready_lat%0d", lat), 32'(ready_w[lat]), exp_ready);
            check($sformatf("rsp_valid_lat%0d", lat), 32'(rsp_v_w[lat]), (gid >= 0) ? (32'd1 << gid) : 32'd0);
            check($sformatf("rsp_c_lat%0d", lat), 32'(rsp_c_w[lat]), 32'(gc));
            check($sformatf("busy_lat%0d", lat), 32'(busy_w[lat]), 32'(exp_busy));
            check($sformatf("op_cnt_lat%0d", lat), cnt_w[lat], m_cnt);
        end
    endtask

    task automatic model_update();
        hist_id[m_cyc] = cur_grant;
        hist_c[m_cyc]  = cur_c;
        if (cur_grant >= 0) begin
            m_ptr = (cur_grant + 1) % NUM_REQ;
            m_cnt = m_cnt + 32'd1;
        end
        last_grant = cur_grant;
        m_cyc++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        drive();
        #1 check_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NUM_REQ; i++) vld[i] = 1'b0;
    endtask

    function automatic int rand_operand();
        case ($urandom_range(4))
            0:       return Q - 1;
            1:       return 0;
            default: return int'($urandom_range(Q - 1));
        endcase
    endfunction

    initial begin
        vec_t vecs [6];
        int   order [5];
        vecs[0] = '{req: 1, a: 3000, b: 1000, c: 159};
        vecs[1] = '{req: 0, a: 3840, b: 1,    c: 0};
        vecs[2] = '{req: 2, a: 0,    b: 0,    c: 0};
        vecs[3] = '{req: 3, a: 3840, b: 3840, c: 3839};
        vecs[4] = '{req: 1, a: 1920, b: 1921, c: 0};
        vecs[5] = '{req: 2, a: 100,  b: 200,  c: 300};
        order   = '{0, 1, 2, 3, 0};

        for (int i = 0; i < HIST; i++) hist_id[i] = -1;
        m_ptr = 0; m_cnt = '0; m_cyc = 0; last_grant = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            vld[i] = 1'b0; oa[i] = 0; ob[i] = 0;
        end
        drive();

        // Reset state, with requests already asserted during reset.
        @(negedge clk);
        step();
        vld[1] = 1'b1; oa[1] = 7; ob[1] = 8;
        step();
        check("reset_ready", 32'(ready_w[2]), 32'd0);
        idle_all();
        rst_n = 1'b1;
        step();

        // Table vectors: single op, observed at each build's latency.
        foreach (vecs[v]) begin
            idle_all();
            vld[vecs[v].req] = 1'b1; oa[vecs[v].req] = vecs[v].a; ob[vecs[v].req] = vecs[v].b;
            drive();
            #1 check($sformatf("vec%0d_c_lat0", v), 32'(rsp_c_w[0]), 32'(vecs[v].c));
            step();
            #1 check($sformatf("vec%0d_c_lat1", v), 32'(rsp_c_w[1]), 32'(vecs[v].c));
            check($sformatf("vec%0d_busy_lat2", v), 32'(busy_w[2]), 32'd1);
            idle_all();
            step();
            #1 check($sformatf("vec%0d_c_lat2", v), 32'(rsp_c_w[2]), 32'(vecs[v].c));
            check($sformatf("vec%0d_v_lat2", v), 32'(rsp_v_w[2]), 32'd1 << vecs[v].req);
            step();
        end

        // Contention from a fresh pointer: strict rotation 0,1,2,3,0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            vld[i] = 1'b1; oa[i] = 1000 * i + 5; ob[i] = 3000 - i;
        end
        foreach (order[k]) begin
            drive();
            #1 check($sformatf("rr_grant%0d", k), 32'(ready_w[2]), 32'd1 << order[k]);
            step();
        end
        idle_all();
        repeat (3) step();

        // Randomized traffic honouring the hold-while-waiting rule.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vld[i] && last_grant != i) begin
                    if ($urandom_range(3) == 0) vld[i] = 1'b0;
                end else begin
                    vld[i] = ((n % 40) < 32) && ($urandom_range(2) != 0);
                    oa[i]  = rand_operand();
                    ob[i]  = rand_operand();
                end
            end
            step();
        end
        idle_all();
        repeat (3) step();

        // Reset one cycle after a grant: the in-flight op must vanish.
        vld[2] = 1'b1; oa[2] = 3000; ob[2] = 1000;
        step();
        idle_all();
        rst_n = 1'b0;
        drive();
        #1 check("midrst_rsp_valid", 32'(rsp_v_w[2]), 32'd0);
        check("midrst_busy", 32'(busy_w[2]), 32'd0);
        check("midrst_op_cnt", cnt_w[2], 32'd0);
        check("midrst_rsp_c", 32'(rsp_c_w[2]), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        #1 check("midrst_no_late_rsp", 32'(rsp_v_w[2]), 32'd0);
        step();

        // Counter wrap from a preloaded value.
        force u_lat0.cnt_q = 32'hFFFF_FFFF;
        force u_lat1.cnt_q = 32'hFFFF_FFFF;
        force u_lat2.cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_lat0.cnt_q;
        release u_lat1.cnt_q;
        release u_lat2.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        vld[0] = 1'b1; oa[0] = 5; ob[0] = 6;
        step();
        #1 check("wrap_first", cnt_w[2], 32'd0);
        vld[0] = 1'b0;
        vld[3] = 1'b1; oa[3] = 9; ob[3] = 10;
        step();
        #1 check("wrap_second", cnt_w[2], 32'd1);
        idle_all();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
